// File: rtl/uart_dbg_controller_if.sv
// MCU debug command bus between the UART debug controller (master) and the MCU core (slave).
interface uart_dbg_controller_if;
    logic [31:0] pc;
    logic        mcu_busy;
    logic [31:0] d_rd;
    logic        error;
    logic [31:0] d_in;
    logic [31:0] addr;
    logic        pause;
    logic        resume;
    logic        mcu_reset;
    logic        reg_rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic        valid;

    modport master (
        input  pc, mcu_busy, d_rd, error,
        output d_in, addr, pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, valid
    );

    modport slave (
        output pc, mcu_busy, d_rd, error,
        input  d_in, addr, pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, valid
    );
endinterface

// File: rtl/uart_dbg_controller.sv
// UART (8N1) debug controller: decodes host command frames into MCU debug strobes
// and returns read data plus a status byte.
module uart_dbg_controller #(
    parameter int CLK_RATE       = 100,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  srx,
    output logic                  stx,
    uart_dbg_controller_if.master dbg
);
    localparam int          BIT_CYCLES = CLK_RATE * 1000000 / BAUD;
    localparam logic [31:0] BIT_M1     = 32'(BIT_CYCLES - 1);
    localparam logic [31:0] HALF_M1    = 32'(BIT_CYCLES / 2 - 1);
    localparam logic [31:0] GAP_LIMIT  = 32'(16 * BIT_CYCLES);
    localparam logic [31:0] TO_M1      = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        ISSUE    = 3'd3,
        WAIT     = 3'd4,
        SEND     = 3'd5
    } state_t;

    function automatic logic is_read(input logic [7:0] op);
        return (op == 8'h04) || (op == 8'h05) || (op == 8'h07);
    endfunction

    function automatic logic needs_data(input logic [7:0] op);
        return (op == 8'h06) || (op == 8'h08) || (op == 8'h09);
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

    logic [1:0]  srx_sync_r;
    logic        srx_prev_r, rx_active_r, rx_valid_r;
    logic [31:0] rx_cnt_r;
    logic [3:0]  rx_idx_r;
    logic [7:0]  rx_shift_r, rx_byte_r;

    logic        stx_r, tx_busy_r, tx_load_s;
    logic [31:0] tx_cnt_r;
    logic [3:0]  tx_bits_r;
    logic [8:0]  tx_shift_r;
    logic [7:0]  tx_byte_s;

    state_t      state_r, next_s;
    logic [7:0]  opcode_r, op_s, status_r;
    logic [31:0] addr_sh_r, data_sh_r, addr_full_s, data_full_s;
    logic [1:0]  byte_cnt_r;
    logic [31:0] gap_cnt_r, wait_cnt_r, rd_data_r;
    logic [2:0]  send_idx_r;
    logic        send_first_r;

    logic        valid_r;
    logic [6:0]  strobe_r;
    logic [31:0] addr_r, d_in_r;
    logic [3:0]  mem_be_r;

    // UART receiver: start-bit check, mid-bit sampling, bytes with a low stop bit are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            srx_sync_r  <= 2'b11;
            srx_prev_r  <= 1'b1;
            rx_active_r <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_cnt_r    <= 32'd0;
            rx_idx_r    <= 4'd0;
            rx_shift_r  <= 8'h00;
            rx_byte_r   <= 8'h00;
        end else begin
            srx_sync_r <= {srx_sync_r[0], srx};
            srx_prev_r <= srx_sync_r[1];
            rx_valid_r <= 1'b0;
            if (!rx_active_r) begin
                if (srx_prev_r && !srx_sync_r[1]) begin
                    rx_active_r <= 1'b1;
                    rx_cnt_r    <= HALF_M1;
                    rx_idx_r    <= 4'd0;
                end
            end else if (rx_cnt_r != 32'd0) begin
                rx_cnt_r <= rx_cnt_r - 32'd1;
            end else begin
                rx_cnt_r <= BIT_M1;
                rx_idx_r <= rx_idx_r + 4'd1;
                if (rx_idx_r == 4'd0) begin
                    if (srx_sync_r[1]) rx_active_r <= 1'b0;
                end else if (rx_idx_r == 4'd9) begin
                    rx_active_r <= 1'b0;
                    if (srx_sync_r[1]) begin
                        rx_valid_r <= 1'b1;
                        rx_byte_r  <= rx_shift_r;
                    end
                end else begin
                    rx_shift_r <= {srx_sync_r[1], rx_shift_r[7:1]};
                end
            end
        end
    end

    // UART transmitter: start bit driven on load, then 8 data bits LSB first and the stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            stx_r      <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_cnt_r   <= 32'd0;
            tx_bits_r  <= 4'd0;
            tx_shift_r <= 9'h1FF;
        end else if (tx_load_s) begin
            stx_r      <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_cnt_r   <= BIT_M1;
            tx_bits_r  <= 4'd9;
            tx_shift_r <= {1'b1, tx_byte_s};
        end else if (tx_busy_r) begin
            if (tx_cnt_r != 32'd0) begin
                tx_cnt_r <= tx_cnt_r - 32'd1;
            end else if (tx_bits_r == 4'd0) begin
                tx_busy_r <= 1'b0;
                stx_r     <= 1'b1;
            end else begin
                stx_r      <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                tx_bits_r  <= tx_bits_r - 4'd1;
                tx_cnt_r   <= BIT_M1;
            end
        end
    end

    // Operand views that include the byte arriving this cycle
    always_comb begin
        if (state_r == IDLE) op_s = rx_byte_r;
        else                 op_s = opcode_r;
        if (state_r == GET_ADDR) addr_full_s = {addr_sh_r[23:0], rx_byte_r};
        else                     addr_full_s = addr_sh_r;
        if (state_r == GET_DATA) data_full_s = {data_sh_r[23:0], rx_byte_r};
        else                     data_full_s = data_sh_r;
        case (send_idx_r)
            3'd0:    tx_byte_s = rd_data_r[31:24];
            3'd1:    tx_byte_s = rd_data_r[23:16];
            3'd2:    tx_byte_s = rd_data_r[15:8];
            3'd3:    tx_byte_s = rd_data_r[7:0];
            3'd4:    tx_byte_s = status_r;
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Command FSM next-state and transmit-load decisions
    always_comb begin
        next_s    = state_r;
        tx_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid_r) begin
                    case (rx_byte_r)
                        8'h01, 8'h02, 8'h03:               next_s = ISSUE;
                        8'h05, 8'h06, 8'h07, 8'h08, 8'h09: next_s = GET_ADDR;
                        default:                           next_s = SEND;
                    endcase
                end else begin
                    next_s = IDLE;
                end
            end
            GET_ADDR, GET_DATA: begin
                if (gap_cnt_r > GAP_LIMIT) begin
                    next_s = IDLE;
                end else if (rx_valid_r && (byte_cnt_r == 2'd3)) begin
                    if (state_r == GET_ADDR && needs_data(opcode_r)) next_s = GET_DATA;
                    else                                             next_s = ISSUE;
                end else begin
                    next_s = state_r;
                end
            end
            ISSUE: next_s = WAIT;
            WAIT: begin
                if (!dbg.mcu_busy || (wait_cnt_r == TO_M1)) next_s = SEND;
                else                                         next_s = WAIT;
            end
            SEND: begin
                if (send_first_r) begin
                    next_s = SEND;
                end else if (send_idx_r == 3'd5) begin
                    if (tx_busy_r) next_s = SEND;
                    else           next_s = IDLE;
                end else begin
                    if (!tx_busy_r) tx_load_s = 1'b1;
                    else            tx_load_s = 1'b0;
                    next_s = SEND;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Frame assembly, wait/timeout bookkeeping and reply sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            opcode_r     <= 8'h00;
            status_r     <= 8'h00;
            addr_sh_r    <= 32'd0;
            data_sh_r    <= 32'd0;
            byte_cnt_r   <= 2'd0;
            gap_cnt_r    <= 32'd0;
            wait_cnt_r   <= 32'd0;
            rd_data_r    <= 32'd0;
            send_idx_r   <= 3'd0;
            send_first_r <= 1'b0;
        end else begin
            state_r <= next_s;
            if (rx_valid_r || (state_r == IDLE)) gap_cnt_r <= 32'd0;
            else                                 gap_cnt_r <= gap_cnt_r + 32'd1;
            if ((next_s == SEND) && (state_r != SEND)) begin
                send_first_r <= 1'b1;
                send_idx_r   <= is_read(op_s) ? 3'd0 : 3'd4;
            end
            case (state_r)
                IDLE: begin
                    if (rx_valid_r) begin
                        opcode_r   <= rx_byte_r;
                        byte_cnt_r <= 2'd0;
                        rd_data_r  <= 32'd0;
                        status_r   <= ((rx_byte_r >= 8'h01) && (rx_byte_r <= 8'h09)) ? 8'h00 : 8'hFF;
                    end
                end
                GET_ADDR: begin
                    if (rx_valid_r) begin
                        addr_sh_r  <= addr_full_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                end
                GET_DATA: begin
                    if (rx_valid_r) begin
                        data_sh_r  <= data_full_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                end
                ISSUE: wait_cnt_r <= 32'd0;
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 32'd1;
                    if (!dbg.mcu_busy) begin
                        rd_data_r <= dbg.d_rd;
                        status_r  <= dbg.error ? 8'h01 : 8'h00;
                    end else if (wait_cnt_r == TO_M1) begin
                        rd_data_r <= 32'd0;
                        status_r  <= 8'hEE;
                    end
                end
                SEND: begin
                    if (send_first_r) begin
                        send_first_r <= 1'b0;
                        if (opcode_r == 8'h04) rd_data_r <= dbg.pc;
                    end else if (tx_load_s) begin
                        send_idx_r <= send_idx_r + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered command outputs: one strobe with valid for the single ISSUE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            strobe_r <= 7'd0;
            addr_r   <= 32'd0;
            d_in_r   <= 32'd0;
            mem_be_r <= 4'd0;
        end else if (next_s == ISSUE) begin
            valid_r <= 1'b1;
            case (op_s)
                8'h01:   begin strobe_r <= 7'b1000000; addr_r <= 32'd0;       d_in_r <= 32'd0;                  mem_be_r <= 4'b0000; end
                8'h02:   begin strobe_r <= 7'b0100000; addr_r <= 32'd0;       d_in_r <= 32'd0;                  mem_be_r <= 4'b0000; end
                8'h03:   begin strobe_r <= 7'b0010000; addr_r <= 32'd0;       d_in_r <= 32'd0;                  mem_be_r <= 4'b0000; end
                8'h05:   begin strobe_r <= 7'b0001000; addr_r <= addr_full_s; d_in_r <= 32'd0;                  mem_be_r <= 4'b0000; end
                8'h06:   begin strobe_r <= 7'b0000100; addr_r <= addr_full_s; d_in_r <= data_full_s;            mem_be_r <= 4'b0000; end
                8'h07:   begin strobe_r <= 7'b0000010; addr_r <= addr_full_s; d_in_r <= 32'd0;                  mem_be_r <= 4'b1111; end
                8'h08:   begin strobe_r <= 7'b0000001; addr_r <= addr_full_s; d_in_r <= data_full_s;            mem_be_r <= 4'b1111; end
                8'h09:   begin strobe_r <= 7'b0000001; addr_r <= addr_full_s; d_in_r <= {4{data_full_s[7:0]}}; mem_be_r <= lane_be(addr_full_s[1:0]); end
                default: begin strobe_r <= 7'd0;       addr_r <= addr_r;      d_in_r <= d_in_r;                 mem_be_r <= mem_be_r; end
            endcase
        end else begin
            valid_r  <= 1'b0;
            strobe_r <= 7'd0;
        end
    end

    assign stx           = stx_r;
    assign dbg.valid     = valid_r;
    assign dbg.pause     = strobe_r[6];
    assign dbg.resume    = strobe_r[5];
    assign dbg.mcu_reset = strobe_r[4];
    assign dbg.reg_rd    = strobe_r[3];
    assign dbg.reg_wr    = strobe_r[2];
    assign dbg.mem_rd    = strobe_r[1];
    assign dbg.mem_wr    = strobe_r[0];
    assign dbg.addr      = addr_r;
    assign dbg.d_in      = d_in_r;
    assign dbg.mem_be    = mem_be_r;
endmodule

// File: tb/tb_uart_dbg_controller.sv
// Directed bench for uart_dbg_controller: host UART frames in, strobes and reply bytes checked.
module tb_uart_dbg_controller;
    localparam int CLK_RATE = 1;
    localparam int BAUD     = 62500;
    localparam int TIMEOUT  = 200;
    localparam int BIT      = 16;

    logic clk = 1'b0;
    logic reset;
    logic srx;
    logic stx;
    uart_dbg_controller_if dbg();

    uart_dbg_controller #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .srx(srx), .stx(stx), .dbg(dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // MCU model: busy for busy_hold cycles after each valid, or permanently when stuck
    int busy_hold  = 0;
    int busy_cnt   = 0;
    bit busy_stuck = 1'b0;
    always @(negedge clk) begin
        if (busy_stuck) begin
            dbg.mcu_busy = 1'b1;
        end else if (dbg.valid === 1'b1) begin
            busy_cnt     = busy_hold;
            dbg.mcu_busy = (busy_hold > 0);
        end else if (busy_cnt > 0) begin
            busy_cnt     = busy_cnt - 1;
            dbg.mcu_busy = (busy_cnt > 0);
        end else begin
            dbg.mcu_busy = 1'b0;
        end
    end

    // Command monitor: snapshot of the bus at each valid, and strobes seen without valid
    int          valid_cnt = 0;
    int          stray_cnt = 0;
    logic [6:0]  mon_strobe;
    logic [31:0] mon_addr, mon_din;
    logic [3:0]  mon_be;
    always @(negedge clk) begin
        if (dbg.valid === 1'b1) begin
            valid_cnt  = valid_cnt + 1;
            mon_strobe = {dbg.pause, dbg.resume, dbg.mcu_reset, dbg.reg_rd, dbg.reg_wr, dbg.mem_rd, dbg.mem_wr};
            mon_addr   = dbg.addr;
            mon_din    = dbg.d_in;
            mon_be     = dbg.mem_be;
        end else if ({dbg.pause, dbg.resume, dbg.mcu_reset, dbg.reg_rd, dbg.reg_wr, dbg.mem_rd, dbg.mem_wr} != 7'd0) begin
            stray_cnt = stray_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        srx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            repeat (BIT) @(negedge clk);
        end
        srx = stop;
        repeat (BIT) @(negedge clk);
        srx = 1'b1;
        if (!stop) repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [71:0] f, input int n);
        for (int k = 0; k < n; k++) send_byte(f[8*(n-1-k) +: 8], 1'b1);
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int waited = 0;
        ok = 1'b0;
        b  = 8'h00;
        while (stx !== 1'b0 && waited < 8000) begin
            @(negedge clk);
            waited++;
        end
        if (stx === 1'b0) begin
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = stx;
            end
            repeat (BIT) @(negedge clk);
            ok = (stx === 1'b1);
        end
    endtask

    task automatic recv_bytes(input int n, output logic [39:0] r, output bit ok);
        logic [7:0] b;
        bit         bok;
        r  = 40'd0;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            recv_byte(b, bok);
            r  = {r[31:0], b};
            ok = ok & bok;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests++; if (stx !== 1'b1) begin fails++; $display("FAIL reset_stx: got %b expected 1", stx); end
        tests++; if (dbg.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dbg.valid); end
        tests++;
        if ({dbg.pause, dbg.resume, dbg.mcu_reset, dbg.reg_rd, dbg.reg_wr, dbg.mem_rd, dbg.mem_wr} !== 7'd0) begin
            fails++; $display("FAIL reset_strobes: got %b expected 0000000",
                {dbg.pause, dbg.resume, dbg.mcu_reset, dbg.reg_rd, dbg.reg_wr, dbg.mem_rd, dbg.mem_wr});
        end
        tests++; if (dbg.addr !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h expected 0", dbg.addr); end
        tests++; if (dbg.d_in !== 32'd0) begin fails++; $display("FAIL reset_d_in: got %h expected 0", dbg.d_in); end
        tests++; if (dbg.mem_be !== 4'd0) begin fails++; $display("FAIL reset_mem_be: got %b expected 0000", dbg.mem_be); end
    endtask

    // Sends a frame, collects n reply bytes, checks reply, valid count and (if any) the captured command
    task automatic run_cmd(input string name, input logic [71:0] f, input int nf, input int nr,
                           input logic [39:0] exp_reply, input int exp_valid, input logic [6:0] exp_strobe,
                           input logic [31:0] exp_addr, input logic [31:0] exp_din, input logic [3:0] exp_be);
        logic [39:0] r;
        bit          ok;
        int          v0;
        v0 = valid_cnt;
        fork
            send_frame(f, nf);
            recv_bytes(nr, r, ok);
        join
        repeat (3 * BIT) @(negedge clk);
        tests++; if (!ok) begin fails++; $display("FAIL %s_reply_framing: reply missing or bad stop bit", name); end
        tests++; if (r !== exp_reply) begin fails++; $display("FAIL %s_reply: got %h expected %h", name, r, exp_reply); end
        tests++; if (valid_cnt - v0 != exp_valid) begin fails++; $display("FAIL %s_valid_pulses: got %0d expected %0d", name, valid_cnt - v0, exp_valid); end
        if (exp_valid == 1) begin
            tests++; if (mon_strobe !== exp_strobe) begin fails++; $display("FAIL %s_strobe: got %b expected %b", name, mon_strobe, exp_strobe); end
            tests++; if (mon_addr !== exp_addr) begin fails++; $display("FAIL %s_addr: got %h expected %h", name, mon_addr, exp_addr); end
            tests++; if (mon_din !== exp_din) begin fails++; $display("FAIL %s_d_in: got %h expected %h", name, mon_din, exp_din); end
            tests++; if (mon_be !== exp_be) begin fails++; $display("FAIL %s_mem_be: got %b expected %b", name, mon_be, exp_be); end
        end
    endtask

    task automatic test_reg_wr;
        busy_hold = 10;
        run_cmd("reg_wr", 72'h06_00000005_DEADBEEF, 9, 1, 40'h00, 1, 7'b0000100, 32'h5, 32'hDEADBEEF, 4'b0000);
        tests++; if (dbg.d_in !== 32'hDEADBEEF) begin fails++; $display("FAIL reg_wr_d_in_hold: got %h expected deadbeef", dbg.d_in); end
    endtask

    task automatic test_mem_rd;
        busy_hold = 3;
        dbg.d_rd  = 32'h12345678;
        run_cmd("mem_rd", 72'h07_00000003, 5, 5, 40'h12345678_00, 1, 7'b0000010, 32'h3, 32'h0, 4'b1111);
    endtask

    task automatic test_reg_rd_error;
        busy_hold = 2;
        dbg.d_rd  = 32'hCAFEF00D;
        dbg.error = 1'b1;
        run_cmd("reg_rd_err", 72'h05_00000007, 5, 5, 40'hCAFEF00D_01, 1, 7'b0001000, 32'h7, 32'h0, 4'b0000);
        dbg.error = 1'b0;
    endtask

    task automatic test_read_pc;
        dbg.pc = 32'h00000100;
        run_cmd("read_pc", 72'h04, 1, 5, 40'h00000100_00, 0, 7'd0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_mem_wr_byte;
        busy_hold = 1;
        run_cmd("mem_wr_byte", 72'h09_00000002_000000AB, 9, 1, 40'h00, 1, 7'b0000001, 32'h2, 32'hABABABAB, 4'b0100);
    endtask

    task automatic test_timeout;
        time t0;
        int  el;
        busy_stuck = 1'b1;
        t0 = $time;
        run_cmd("timeout", 72'h01, 1, 1, 40'hEE, 1, 7'b1000000, 32'h0, 32'h0, 4'b0000);
        el = int'(($time - t0) / 10) - 3 * BIT;
        tests++; if (el < 480 || el > 560) begin fails++; $display("FAIL timeout_latency: got %0d cycles expected 480..560", el); end
        busy_stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unknown;
        run_cmd("unknown", 72'h7F, 1, 1, 40'hFF, 0, 7'd0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_gap_abort;
        send_frame(72'h06_00, 2);
        repeat (20 * BIT) @(negedge clk);
        run_cmd("gap_abort", 72'h7F, 1, 1, 40'hFF, 0, 7'd0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_bad_stop;
        send_byte(8'h7F, 1'b0);
        run_cmd("bad_stop", 72'h04, 1, 5, 40'h00000100_00, 0, 7'd0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid_tx;
        int waited = 0;
        int lows   = 0;
        fork
            send_frame(72'h04, 1);
            while (stx !== 1'b0 && waited < 8000) begin
                @(negedge clk);
                waited++;
            end
        join
        repeat (2 * BIT) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (stx !== 1'b1) begin fails++; $display("FAIL reset_mid_tx_stx: got %b expected 1", stx); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12 * BIT; i++) begin
            @(negedge clk);
            if (stx !== 1'b1) lows++;
        end
        tests++; if (lows != 0) begin fails++; $display("FAIL reset_mid_tx_truncated: got %0d low cycles expected 0", lows); end
    endtask

    initial begin
        srx       = 1'b1;
        reset     = 1'b1;
        dbg.pc    = 32'd0;
        dbg.d_rd  = 32'd0;
        dbg.error = 1'b0;
        test_reset();
        repeat (4) @(negedge clk);
        test_reg_wr();
        test_mem_rd();
        test_reg_rd_error();
        test_read_pc();
        test_mem_wr_byte();
        test_timeout();
        test_unknown();
        test_gap_abort();
        test_bad_stop();
        test_reset_mid_tx();
        tests++; if (stray_cnt != 0) begin fails++; $display("FAIL strobe_without_valid: got %0d cycles expected 0", stray_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
